// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, funct3 codes, ALU operation enum and
// the funct3 -> ALU operation mapping used by both immediate and register ops.
package riscv_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
   } alu_op_t;

   // alt is instr[30]: selects SUB over ADD and SRA over SRL
   function automatic alu_op_t alu_op_decode(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_SLT:  return ALU_SLT;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return alt ? ALU_SRA : ALU_SRL;
         F3_OR:   return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational 32-bit ALU; shift amount is the low five bits of b.
module riscv_alu
   import riscv_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_op_t     op,
   output logic [31:0] result
);

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:    result = a + b;
         ALU_SUB:    result = a - b;
         ALU_SLL:    result = a << b[4:0];
         ALU_SLT:    result = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU:   result = {31'd0, a < b};
         ALU_XOR:    result = a ^ b;
         ALU_SRL:    result = a >> b[4:0];
         ALU_SRA:    result = $unsigned($signed(a) >>> b[4:0]);
         ALU_OR:     result = a | b;
         ALU_AND:    result = a & b;
         ALU_PASS_B: result = b;
         default:    result = '0;
      endcase
   end

endmodule

// File: rtl/riscv_cpu_dmem.sv
// Byte-addressed data memory: combinational 4-byte little-endian read window,
// synchronous byte/half/word write; misaligned accesses wrap byte-wise.
module riscv_cpu_dmem #(
   parameter int BYTES = 1024
) (
   input  logic        clock,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);

   localparam int AW = $clog2(BYTES);

   logic [7:0]    memory [0:BYTES-1];
   logic [AW-1:0] a0, a1, a2, a3;
   logic          unused_bits;

   assign a0 = addr[AW-1:0];
   assign a1 = a0 + AW'(1);
   assign a2 = a0 + AW'(2);
   assign a3 = a0 + AW'(3);
   assign unused_bits = ^addr[31:AW];
   assign rdata = {memory[a3], memory[a2], memory[a1], memory[a0]};

   // NOTE: the array has no reset branch; clearing it would turn it into flops.
   always_ff @(posedge clock) begin
      if (we) begin
         memory[a0] <= wdata[7:0];
         if (size != 2'b00) memory[a1] <= wdata[15:8];
         if (size == 2'b10) begin
            memory[a2] <= wdata[23:16];
            memory[a3] <= wdata[31:24];
         end
      end
   end

endmodule

// File: rtl/riscv_cpu_imem.sv
// Byte-addressed instruction memory, preloaded by the environment; little-endian
// combinational fetch with the address wrapping at BYTES.
module riscv_cpu_imem #(
   parameter int BYTES = 1024
) (
   input  logic [31:0] pc,
   output logic [31:0] instr
);

   localparam int AW = $clog2(BYTES);

   logic [7:0]    memory [0:BYTES-1];
   logic [AW-1:0] a0;
   logic          unused_bits;

   assign a0          = pc[AW-1:0];
   assign unused_bits = ^pc[31:AW];
   assign instr = {memory[a0 + AW'(3)], memory[a0 + AW'(2)],
                   memory[a0 + AW'(1)], memory[a0]};

endmodule

// File: rtl/riscv_cpu_pc.sv
// Program counter register with synchronous reset to RESET_PC.
module riscv_cpu_pc #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] next_pc,
   output logic [31:0] pc_addr
);

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) pc_addr <= RESET_PC;
      else       pc_addr <= next_pc;
   end

endmodule

// File: rtl/riscv_cpu_regfile.sv
// 32x32 register file: two combinational read ports, one write port, x0 hardwired to 0.
module riscv_cpu_regfile (
   input  logic        clock,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  rd,
   input  logic [31:0] wdata,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2
);

   logic [31:0] registers [0:31];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) registers[i] <= '0;
      end else if (we && rd != 5'd0) begin
         registers[rd] <= wdata;
      end
   end

   assign rdata1 = (rs1 == 5'd0) ? '0 : registers[rs1];
   assign rdata2 = (rs2 == 5'd0) ? '0 : registers[rs2];

endmodule

// File: rtl/riscv_cpu.sv
// Single-cycle RV32I core. Define HALT_ON_ILLEGAL_EN to freeze the PC on
// undefined opcodes, ECALL and EBREAK; otherwise they execute as NOPs.
module riscv_cpu
   import riscv_pkg::*;
#(
   parameter int          IMEM_BYTES = 1024,
   parameter int          DMEM_BYTES = 1024,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] out
);

   logic [31:0] pc_addr, next_pc, instr, link;
   logic [31:0] rs1_data, rs2_data, alu_a, alu_b, alu_result;
   logic [31:0] mem_rdata, load_data, result;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [6:0]  opcode;
   logic [2:0]  f3;
   alu_op_t     alu_op;
   logic        reg_we, mem_we, legal, take_branch;

   riscv_cpu_pc #(.RESET_PC(RESET_PC)) program_counter (
      .clock(clock), .reset(reset), .next_pc(next_pc), .pc_addr(pc_addr)
   );

   riscv_cpu_imem #(.BYTES(IMEM_BYTES)) uut_instruction (
      .pc(pc_addr), .instr(instr)
   );

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u  = {instr[31:12], 12'd0};
   assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign link   = pc_addr + 32'd4;

   riscv_cpu_regfile registers_bank (
      .clock(clock), .reset(reset), .we(reg_we & ~reset), .rd(instr[11:7]),
      .wdata(result), .rs1(instr[19:15]), .rs2(instr[24:20]),
      .rdata1(rs1_data), .rdata2(rs2_data)
   );

   riscv_alu alu (.a(alu_a), .b(alu_b), .op(alu_op), .result(alu_result));

   riscv_cpu_dmem #(.BYTES(DMEM_BYTES)) memory (
      .clock(clock), .we(mem_we & ~reset), .size(f3[1:0]), .addr(alu_result),
      .wdata(rs2_data), .rdata(mem_rdata)
   );

   always_comb begin
      take_branch = 1'b0;
      case (f3)
         F3_BEQ:  take_branch = (rs1_data == rs2_data);
         F3_BNE:  take_branch = (rs1_data != rs2_data);
         F3_BLT:  take_branch = ($signed(rs1_data) <  $signed(rs2_data));
         F3_BGE:  take_branch = ($signed(rs1_data) >= $signed(rs2_data));
         F3_BLTU: take_branch = (rs1_data <  rs2_data);
         F3_BGEU: take_branch = (rs1_data >= rs2_data);
         default: take_branch = 1'b0;
      endcase
   end

   always_comb begin
      load_data = '0;
      case (f3)
         F3_B:    load_data = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
         F3_H:    load_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
         F3_W:    load_data = mem_rdata;
         F3_BU:   load_data = {24'd0, mem_rdata[7:0]};
         F3_HU:   load_data = {16'd0, mem_rdata[15:0]};
         default: load_data = '0;
      endcase
   end

   always_comb begin
      // NOTE: every output gets a default first so no decode path infers a latch.
      alu_a   = rs1_data;
      alu_b   = imm_i;
      alu_op  = ALU_ADD;
      result  = '0;
      next_pc = link;
      reg_we  = 1'b0;
      mem_we  = 1'b0;
      legal   = 1'b1;
      case (opcode)
         OP_LUI: begin
            alu_b = imm_u; alu_op = ALU_PASS_B; result = alu_result; reg_we = 1'b1;
         end
         OP_AUIPC: begin
            alu_a = pc_addr; alu_b = imm_u; result = alu_result; reg_we = 1'b1;
         end
         OP_JAL: begin
            result = link; next_pc = pc_addr + imm_j; reg_we = 1'b1;
         end
         OP_JALR: begin
            result = link; next_pc = alu_result & ~32'd1; reg_we = 1'b1;
            legal  = (f3 == 3'b000);
         end
         OP_BRANCH: begin
            if (take_branch) next_pc = pc_addr + imm_b;
            legal = (f3[2:1] != 2'b01);
         end
         OP_LOAD: begin
            result = load_data; reg_we = 1'b1;
            legal  = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
         end
         OP_STORE: begin
            alu_b  = imm_s; mem_we = 1'b1;
            legal  = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
         end
         OP_IMM: begin
            alu_op = alu_op_decode(f3, (f3 == F3_SR) && instr[30]);
            result = alu_result; reg_we = 1'b1;
         end
         OP_REG: begin
            alu_b  = rs2_data; alu_op = alu_op_decode(f3, instr[30]);
            result = alu_result; reg_we = 1'b1;
         end
         OP_FENCE:  legal = 1'b1;
         OP_SYSTEM: legal = 1'b0;
         default:   legal = 1'b0;
      endcase
      if (!legal) begin
         result = '0;
         reg_we = 1'b0;
         mem_we = 1'b0;
`ifdef HALT_ON_ILLEGAL_EN
         next_pc = pc_addr;
`else
         next_pc = link;
`endif
      end
   end

   assign out = result;

endmodule

// File: tb/tb_riscv_cpu.sv
// Directed self-checking bench for riscv_cpu: programs are hand-encoded into
// instruction memory and architectural state is compared against hand-computed values.
module tb_riscv_cpu;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] out;
   int          n_tests = 0;
   int          n_fail  = 0;

   riscv_cpu dut (.clock(clock), .reset(reset), .out(out));

   always #5 clock = ~clock;

   function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [31:0] imm);
      return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
   endfunction

   function automatic logic [31:0] reg_val(input int i);
      return dut.registers_bank.registers[i];
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 1024; i++) dut.uut_instruction.memory[i] = 8'h00;
   endtask

   task automatic put(input int addr, input logic [31:0] w);
      for (int b = 0; b < 4; b++) dut.uut_instruction.memory[addr + b] = w[8*b +: 8];
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      clear_imem();
      put(0, addi(5'd1, 5'd0, 32'd5));
      put(4, addi(5'd2, 5'd0, 32'd6));
      put(8, addi(5'd31, 5'd0, 32'd7));
      do_reset();
      n_tests++;
      if (dut.program_counter.pc_addr !== 32'd0) begin
         n_fail++; $display("FAIL reset_pc: got %h want %h", dut.program_counter.pc_addr, 32'd0);
      end
      step(3);
      do_reset();
      n_tests++;
      if (dut.program_counter.pc_addr !== 32'd0) begin
         n_fail++; $display("FAIL reset_pc_dirty: got %h want %h", dut.program_counter.pc_addr, 32'd0);
      end
      for (int i = 1; i < 32; i++) begin
         n_tests++;
         if (reg_val(i) !== 32'd0) begin
            n_fail++; $display("FAIL reset_x%0d: got %h want %h", i, reg_val(i), 32'd0);
         end
      end
   endtask

   task automatic test_addi();
      clear_imem();
      put(0, addi(5'd1, 5'd0, 32'd5));
      put(4, addi(5'd2, 5'd1, -32'sd7));
      put(8, addi(5'd0, 5'd0, 32'd1));
      do_reset();
      n_tests++;
      if (out !== 32'd5) begin
         n_fail++; $display("FAIL addi_out: got %h want %h", out, 32'd5);
      end
      step(2);
      n_tests++;
      if (reg_val(1) !== 32'd5 || reg_val(2) !== 32'hFFFF_FFFE) begin
         n_fail++; $display("FAIL addi_chain: got x1=%h x2=%h want x1=%h x2=%h",
                            reg_val(1), reg_val(2), 32'd5, 32'hFFFF_FFFE);
      end
      n_tests++;
      if (dut.program_counter.pc_addr !== 32'd8) begin
         n_fail++; $display("FAIL addi_pc: got %h want %h", dut.program_counter.pc_addr, 32'd8);
      end
      step(1);
      n_tests++;
      if (reg_val(0) !== 32'd0) begin
         n_fail++; $display("FAIL x0_write: got %h want %h", reg_val(0), 32'd0);
      end
   endtask

   task automatic test_memory();
      logic [7:0] exp_bytes [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
      clear_imem();
      put(0,  {20'h12345, 5'd3, 7'b0110111});
      put(4,  addi(5'd3, 5'd3, 32'h678));
      put(8,  enc_s(32'd0, 5'd3, 5'd0, 3'b010));
      put(12, enc_i(32'd1, 5'd0, 3'b000, 5'd4, 7'b0000011));
      put(16, enc_i(32'd3, 5'd0, 3'b100, 5'd5, 7'b0000011));
      put(20, addi(5'd6, 5'd0, -32'sd128));
      put(24, enc_s(32'd8, 5'd6, 5'd0, 3'b000));
      put(28, enc_i(32'd8, 5'd0, 3'b000, 5'd7, 7'b0000011));
      put(32, enc_i(32'd1, 5'd0, 3'b001, 5'd8, 7'b0000011));
      do_reset();
      step(5);
      n_tests++;
      if (reg_val(3) !== 32'h1234_5678) begin
         n_fail++; $display("FAIL lui_addi: got %h want %h", reg_val(3), 32'h1234_5678);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (dut.memory.memory[i] !== exp_bytes[i]) begin
            n_fail++; $display("FAIL sw_byte%0d: got %h want %h", i, dut.memory.memory[i], exp_bytes[i]);
         end
      end
      n_tests++;
      if (reg_val(4) !== 32'h0000_0056 || reg_val(5) !== 32'h0000_0012) begin
         n_fail++; $display("FAIL lb_lbu: got x4=%h x5=%h want x4=%h x5=%h",
                            reg_val(4), reg_val(5), 32'h56, 32'h12);
      end
      step(1);
      n_tests++;
      if (out !== 32'd0) begin
         n_fail++; $display("FAIL store_out: got %h want %h", out, 32'd0);
      end
      step(3);
      n_tests++;
      if (reg_val(7) !== 32'hFFFF_FF80) begin
         n_fail++; $display("FAIL sb_lb_sign: got %h want %h", reg_val(7), 32'hFFFF_FF80);
      end
      n_tests++;
      if (reg_val(8) !== 32'h0000_3456) begin
         n_fail++; $display("FAIL lh_misaligned: got %h want %h", reg_val(8), 32'h0000_3456);
      end
   endtask

   task automatic test_alu();
      int          idx [7] = '{10, 11, 12, 13, 14, 15, 16};
      logic [31:0] ev  [7] = '{32'd7, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'h0000_000F,
                               32'hFFFF_FFFB, 32'h8000_0000};
      clear_imem();
      put(0,  addi(5'd1, 5'd0, 32'd5));
      put(4,  addi(5'd2, 5'd0, -32'sd2));
      put(8,  enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd10));
      put(12, enc_r(7'b0000000, 5'd1, 5'd2, 3'b010, 5'd11));
      put(16, enc_r(7'b0000000, 5'd1, 5'd2, 3'b011, 5'd12));
      put(20, enc_r(7'b0100000, 5'd1, 5'd2, 3'b101, 5'd13));
      put(24, enc_i(32'd28, 5'd2, 3'b101, 5'd14, 7'b0010011));
      put(28, enc_r(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd15));
      put(32, enc_i(32'd31, 5'd1, 3'b001, 5'd16, 7'b0010011));
      do_reset();
      step(9);
      for (int i = 0; i < 7; i++) begin
         n_tests++;
         if (reg_val(idx[i]) !== ev[i]) begin
            n_fail++; $display("FAIL alu_x%0d: got %h want %h", idx[i], reg_val(idx[i]), ev[i]);
         end
      end
   endtask

   task automatic test_branch();
      logic [31:0] pcs [4] = '{32'd20, 32'd24, 32'd32, 32'd36};
      clear_imem();
      put(0,  addi(5'd1, 5'd0, 32'd5));
      put(4,  addi(5'd2, 5'd0, -32'sd2));
      put(8,  enc_b(32'd12, 5'd0, 5'd0, 3'b000));
      put(12, addi(5'd20, 5'd0, 32'd1));
      put(16, addi(5'd20, 5'd0, 32'd1));
      put(20, enc_b(32'd12, 5'd0, 5'd0, 3'b001));
      put(24, enc_b(32'd8, 5'd1, 5'd2, 3'b100));
      put(28, addi(5'd20, 5'd0, 32'd1));
      put(32, enc_b(32'd8, 5'd1, 5'd2, 3'b110));
      do_reset();
      step(2);
      n_tests++;
      if (out !== 32'd0) begin
         n_fail++; $display("FAIL branch_out: got %h want %h", out, 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         step(1);
         n_tests++;
         if (dut.program_counter.pc_addr !== pcs[i]) begin
            n_fail++; $display("FAIL branch_pc%0d: got %h want %h", i, dut.program_counter.pc_addr, pcs[i]);
         end
      end
      n_tests++;
      if (reg_val(20) !== 32'd0) begin
         n_fail++; $display("FAIL branch_skip: got %h want %h", reg_val(20), 32'd0);
      end
   endtask

   task automatic test_jump();
      clear_imem();
      for (int a = 0; a < 16; a += 4) put(a, addi(5'd0, 5'd0, 32'd0));
      put(16, enc_j(32'd16, 5'd1));
      put(32, enc_i(32'd1, 5'd1, 3'b000, 5'd0, 7'b1100111));
      do_reset();
      step(4);
      n_tests++;
      if (out !== 32'h14) begin
         n_fail++; $display("FAIL jal_out: got %h want %h", out, 32'h14);
      end
      step(1);
      n_tests++;
      if (reg_val(1) !== 32'h14 || dut.program_counter.pc_addr !== 32'h20) begin
         n_fail++; $display("FAIL jal: got x1=%h pc=%h want x1=%h pc=%h",
                            reg_val(1), dut.program_counter.pc_addr, 32'h14, 32'h20);
      end
      step(1);
      n_tests++;
      if (dut.program_counter.pc_addr !== 32'h14) begin
         n_fail++; $display("FAIL jalr_pc: got %h want %h", dut.program_counter.pc_addr, 32'h14);
      end
   endtask

   task automatic test_undefined();
      clear_imem();
      for (int a = 0; a < 36; a += 4) put(a, addi(5'd0, 5'd0, 32'd0));
      put(40, 32'h0000_0073);
      do_reset();
      step(9);
      n_tests++;
      if (out !== 32'd0) begin
         n_fail++; $display("FAIL undef_out: got %h want %h", out, 32'd0);
      end
      step(1);
      n_tests++;
      if (dut.program_counter.pc_addr !== 32'h28) begin
         n_fail++; $display("FAIL undef_pc: got %h want %h", dut.program_counter.pc_addr, 32'h28);
      end
      step(1);
      n_tests++;
      if (dut.program_counter.pc_addr !== 32'h2C) begin
         n_fail++; $display("FAIL ecall_pc: got %h want %h", dut.program_counter.pc_addr, 32'h2C);
      end
      for (int i = 1; i < 32; i++) begin
         n_tests++;
         if (reg_val(i) !== 32'd0) begin
            n_fail++; $display("FAIL undef_x%0d: got %h want %h", i, reg_val(i), 32'd0);
         end
      end
   endtask

   task automatic test_mid_reset();
      clear_imem();
      put(0,  addi(5'd1, 5'd0, 32'd5));
      put(4,  enc_s(32'd16, 5'd1, 5'd0, 3'b000));
      put(8,  addi(5'd2, 5'd0, 32'h33));
      put(12, enc_s(32'd16, 5'd2, 5'd0, 3'b000));
      do_reset();
      step(3);
      do_reset();
      n_tests++;
      if (dut.program_counter.pc_addr !== 32'd0) begin
         n_fail++; $display("FAIL mid_reset_pc: got %h want %h", dut.program_counter.pc_addr, 32'd0);
      end
      n_tests++;
      if (dut.memory.memory[16] !== 8'h05) begin
         n_fail++; $display("FAIL mid_reset_store: got %h want %h", dut.memory.memory[16], 8'h05);
      end
      step(1);
      n_tests++;
      if (reg_val(1) !== 32'd5 || dut.program_counter.pc_addr !== 32'd4) begin
         n_fail++; $display("FAIL mid_reset_resume: got x1=%h pc=%h want x1=%h pc=%h",
                            reg_val(1), dut.program_counter.pc_addr, 32'd5, 32'd4);
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_memory();
      test_alu();
      test_branch();
      test_jump();
      test_undefined();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
